// File: rtl/sync_gsram.sv
// Byte-enabled synchronous SRAM slave mapped at [START_ADDR, START_ADDR+SIZE).
// Each access is captured in IDLE, waits WAIT_STATES cycles, completes with a one-cycle ready pulse.
module sync_gsram #(
    parameter  int START_ADDR  = 0,
    parameter  int SIZE        = 256,
    parameter  int ADDR_WIDTH  = 16,
    parameter  int DATA_WIDTH  = 16,
    parameter  int WAIT_STATES = 2,
    localparam int BE_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BE_WIDTH-1:0]   be,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  error,
    output logic                  busy
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    // One extra bit so START_ADDR+SIZE == 2**ADDR_WIDTH does not wrap to zero.
    localparam logic [ADDR_WIDTH:0] RANGE_LO = (ADDR_WIDTH + 1)'(START_ADDR);
    localparam logic [ADDR_WIDTH:0] RANGE_HI = (ADDR_WIDTH + 1)'(START_ADDR + SIZE);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $fatal(1, "sync_gsram: DATA_WIDTH must be a multiple of 8");
    end
    if (SIZE == 0) begin : g_bad_size
        $fatal(1, "sync_gsram: SIZE must be non-zero");
    end
    if ((64'(START_ADDR) + 64'(SIZE)) > (64'd1 << ADDR_WIDTH)) begin : g_bad_map
        $fatal(1, "sync_gsram: START_ADDR+SIZE exceeds the address space");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;
    logic                  mem_wr;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;

    // NOTE: the array has no reset branch -- contents must survive rst, and a reset
    // would stop it mapping onto RAM macros; it starts at zero via its declaration.
    logic [DATA_WIDTH-1:0] mem_q [SIZE] = '{default: '0};

    assign in_range = ({1'b0, addr_q} >= RANGE_LO) && ({1'b0, addr_q} < RANGE_HI);
    assign idx      = IDX_W'(addr_q - ADDR_WIDTH'(START_ADDR));

    // NOTE: every signal written here gets a default first; a path that leaves one
    // unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        error_d = 1'b0;
        mem_wr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = address;
                    wdata_d = wdata;
                    be_d    = be;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ready_d = 1'b1;
                error_d = !in_range;
                mem_wr  = we_q && in_range;
                if (!we_q) begin
                    rdata_d = in_range ? mem_q[idx] : '0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    // Only the ACCESS state can write, so a reset during WAIT/ACCESS aborts cleanly.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (be_q[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign error = error_q;
    assign busy  = (state_q != IDLE);

endmodule
